// File: rtl/dcache_responder.sv
// rtl/dcache_responder.sv - direct-mapped write-through data-cache responder
//
// Purpose: serves load/store accesses from the memory stage out of a small
// direct-mapped cache and a backing-memory port. Write-through, no write
// allocate. Loads that miss refill a whole line, one word per memory transfer.
//
// Ports:
//   clk_i, rst_n_i     clock, asynchronous active-low reset
//   cache_req_i        access request (addr/wdata/wr held until valid_o)
//   wr_i               1 = store, 0 = load
//   addr_i, wdata_i    byte address (bits [1:0] ignored), store data
//   rdata_o, valid_o   load data (held) and one-cycle completion pulse
//   mem_req_o, mem_wr_o, mem_addr_o, mem_wdata_o   backing-memory request
//   mem_rdata_i, mem_ready_i                       backing-memory response
module dcache_responder #(
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        cache_req_i,
  input  logic        wr_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        valid_o,
  output logic        mem_req_o,
  output logic        mem_wr_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ready_i
);

  localparam int IDX    = $clog2(LINES);
  localparam int WOFF_W = $clog2(WORDS_PER_LINE);
  localparam int OFF    = 2 + WOFF_W;
  localparam int TAG_W  = 32 - OFF - IDX;
  localparam int NWORDS = LINES * WORDS_PER_LINE;
  localparam logic [WOFF_W-1:0] CNT_LAST = WOFF_W'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {S_IDLE, S_REFILL, S_WRITE, S_RESP} state_e;

  state_e              state_q, state_d;
  logic [WOFF_W-1:0]   cnt_q, cnt_d;
  logic [LINES-1:0]    valid_q, valid_d;
  logic [29:0]         req_addr_q, req_addr_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                valid_o_q, valid_o_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_wr_q, mem_wr_d;
  logic [31:0]         mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;

  // Tag and data storage carry no reset; valid_q alone qualifies them.
  logic [TAG_W-1:0]    tag_q  [LINES];
  logic [31:0]         data_q [NWORDS];

  logic                data_we;
  logic [IDX+WOFF_W-1:0] data_widx;
  logic [31:0]         data_wval;
  logic                tag_we;

  // Fields of the incoming address (used while IDLE).
  logic [TAG_W-1:0]    in_tag;
  logic [IDX-1:0]      in_idx;
  logic [WOFF_W-1:0]   in_woff;
  logic                in_hit;

  // Fields of the accepted address; a flushed request may let addr_i move.
  logic [TAG_W-1:0]    q_tag;
  logic [IDX-1:0]      q_idx;
  logic [WOFF_W-1:0]   q_woff;

  logic                unused_addr_bits;

  assign in_tag  = addr_i[31:OFF+IDX];
  assign in_idx  = addr_i[OFF+IDX-1:OFF];
  assign in_woff = addr_i[OFF-1:2];
  assign in_hit  = valid_q[in_idx] && (tag_q[in_idx] == in_tag);

  assign q_tag   = req_addr_q[29:WOFF_W+IDX];
  assign q_idx   = req_addr_q[WOFF_W+IDX-1:WOFF_W];
  assign q_woff  = req_addr_q[WOFF_W-1:0];

  assign unused_addr_bits = ^addr_i[1:0];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    valid_d     = valid_q;
    req_addr_d  = req_addr_q;
    rdata_d     = rdata_q;
    valid_o_d   = 1'b0;
    mem_req_d   = mem_req_q;
    mem_wr_d    = mem_wr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    data_we     = 1'b0;
    data_widx   = {in_idx, in_woff};
    data_wval   = wdata_i;
    tag_we      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (cache_req_i) begin
          req_addr_d = addr_i[31:2];
          if (wr_i) begin
            // Write-through: the word is patched in place only if resident.
            state_d     = S_WRITE;
            mem_req_d   = 1'b1;
            mem_wr_d    = 1'b1;
            mem_addr_d  = {addr_i[31:2], 2'b00};
            mem_wdata_d = wdata_i;
            data_we     = in_hit;
          end else if (in_hit) begin
            state_d   = S_RESP;
            rdata_d   = data_q[{in_idx, in_woff}];
            valid_o_d = 1'b1;
          end else begin
            // The line is invalid until every word has arrived.
            state_d         = S_REFILL;
            cnt_d           = '0;
            valid_d[in_idx] = 1'b0;
            mem_req_d       = 1'b1;
            mem_wr_d        = 1'b0;
            mem_addr_d      = {in_tag, in_idx, {WOFF_W{1'b0}}, 2'b00};
          end
        end
      end

      S_REFILL: begin
        if (mem_ready_i) begin
          data_we   = 1'b1;
          data_widx = {q_idx, cnt_q};
          data_wval = mem_rdata_i;
          if (cnt_q == CNT_LAST) begin
            tag_we         = 1'b1;
            valid_d[q_idx] = 1'b1;
            // The last word is not yet in the array, so bypass it.
            rdata_d     = (cnt_q == q_woff) ? mem_rdata_i : data_q[{q_idx, q_woff}];
            valid_o_d   = 1'b1;
            state_d     = S_RESP;
            cnt_d       = '0;
            mem_req_d   = 1'b0;
            mem_wr_d    = 1'b0;
            mem_addr_d  = '0;
            mem_wdata_d = '0;
          end else begin
            cnt_d      = cnt_q + WOFF_W'(1);
            mem_addr_d = {q_tag, q_idx, cnt_q + WOFF_W'(1), 2'b00};
          end
        end
      end

      S_WRITE: begin
        if (mem_ready_i) begin
          valid_o_d   = 1'b1;
          state_d     = S_RESP;
          mem_req_d   = 1'b0;
          mem_wr_d    = 1'b0;
          mem_addr_d  = '0;
          mem_wdata_d = '0;
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      valid_q     <= '0;
      req_addr_q  <= '0;
      rdata_q     <= '0;
      valid_o_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      valid_q     <= valid_d;
      req_addr_q  <= req_addr_d;
      rdata_q     <= rdata_d;
      valid_o_q   <= valid_o_d;
      mem_req_q   <= mem_req_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (data_we) begin
      data_q[data_widx] <= data_wval;
    end
    if (tag_we) begin
      tag_q[q_idx] <= q_tag;
    end
  end

  assign rdata_o     = rdata_q;
  assign valid_o     = valid_o_q;
  assign mem_req_o   = mem_req_q;
  assign mem_wr_o    = mem_wr_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule
